// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle between the 5-stage core datapath and its pipeline sequencer.
// Data-memory handshake: mem_req stays high while the MEM stage holds a load/store;
// mem_ack is high for the single cycle in which that access completes. The access
// counts as outstanding (stall) only while mem_req=1 and mem_ack=0. Dropping mem_req
// without an ack ends the wait just as an ack would.
interface pipe_hazard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              ex_memRead;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_br_taken;
  logic              mem_req;
  logic              mem_ack;
  logic              pc_en;
  logic              if_id_en;
  logic              if_id_flush;
  logic              id_ex_en;
  logic              id_ex_flush;
  logic              ex_mem_en;
  logic              mem_wb_flush;
  logic [1:0]        fsm_state;
  logic              timeout_err;
  logic [CNT_W-1:0]  stall_cnt;

  // Datapath side: supplies hazard information, consumes enables/flushes.
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memRead, ex_rd,
           ex_br_taken, mem_req, mem_ack,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_flush, fsm_state, timeout_err, stall_cnt
  );

  // Sequencer side.
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memRead, ex_rd,
           ex_br_taken, mem_req, mem_ack,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_flush, fsm_state, timeout_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RISC-V core: load-use stalls, taken-branch
// flushes and data-memory wait stalls, plus a sticky memory timeout flag and a
// saturating count of cycles in which the PC was held.
module pipe_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int BR_PENALTY  = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  pipe_hazard_if.slave hz
);
  localparam int BR_W = (BR_PENALTY > 1) ? $clog2(BR_PENALTY) : 1;
  localparam int WT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [BR_W-1:0] BR_RELOAD = BR_W'(BR_PENALTY - 1);
  localparam logic [WT_W-1:0] WT_MAX    = WT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    BR_FLUSH = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [BR_W-1:0]  br_cnt, br_cnt_nxt;
  logic [WT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cnt;

  logic mem_stall, lu;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;

  assign mem_stall = hz.mem_req & ~hz.mem_ack;
  assign lu = hz.ex_memRead & (hz.ex_rd != '0) &
              ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
               (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));

  // State, counters and sticky timeout; reset abandons any wait or flush in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      br_cnt      <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      br_cnt   <= br_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (mem_stall && (wait_cnt == WT_MAX)) timeout_err <= 1'b1;
      if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Next state and Mealy controls; priority is memory stall, then branch, then load-use.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_flush = 1'b0;
    state_nxt    = state;
    br_cnt_nxt   = br_cnt;
    wait_cnt_nxt = '0;
    if (mem_stall) begin
      // Freeze everything up to MEM; a bubble goes into WB. Branch countdown is held.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
      state_nxt    = MEM_WAIT;
      wait_cnt_nxt = (wait_cnt == WT_MAX) ? wait_cnt : wait_cnt + WT_W'(1);
    end else if (hz.ex_br_taken) begin
      // PC loads the target this cycle; the two younger instructions are wrong-path.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      if (BR_PENALTY == 1) begin
        br_cnt_nxt = '0;
        state_nxt  = RUN;
      end else begin
        br_cnt_nxt = BR_RELOAD;
        state_nxt  = BR_FLUSH;
      end
    end else begin
      case (state)
        RUN: begin
          if (lu) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        BR_FLUSH: begin
          // Load-use is ignored here: the ID instruction is being flushed anyway.
          if (br_cnt != '0) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            br_cnt_nxt  = br_cnt - BR_W'(1);
            if (br_cnt == BR_W'(1)) state_nxt = RUN;
          end else begin
            state_nxt = RUN;
          end
        end
        MEM_WAIT: begin
          // Ack (or dropped request) releases in this same cycle; resume any held flush.
          state_nxt = (br_cnt != '0) ? BR_FLUSH : RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.if_id_en     = if_id_en;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_en     = id_ex_en;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_en    = ex_mem_en;
  assign hz.mem_wb_flush = mem_wb_flush;
  assign hz.fsm_state    = state;
  assign hz.timeout_err  = timeout_err;
  assign hz.stall_cnt    = stall_cnt;
endmodule
